// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop add two WIDTH-bit
// operands LSB-first, one bit per clock; the registered result holds until the next completion.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only WIDTH-1 bits are buffered; the MSB goes straight from the adder cell into sum.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             bit_c;

  assign bit_s = sa_q[0] ^ sb_q[0] ^ c_q;
  assign bit_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one unassigned (no latches).
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = bit_c;
        acc_d = (WIDTH-1)'({bit_s, acc_q} >> 1);
        if (cnt_q == LAST_BIT) begin
          // c_q is the carry into the MSB on this cycle; bit_c is the carry out of it.
          sum_d   = {bit_s, acc_q};
          cout_d  = bit_c;
          ovf_d   = c_q ^ bit_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=8): hand-computed sums, latency,
// busy window, ignored start while busy, back-to-back starts and mid-add reset.
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one add from IDLE and check latency, busy window and results.
  task automatic do_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int n;
    int busy_cycles;
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 20) begin
      if (busy) busy_cycles++;
      tick();
      n++;
    end
    if (busy) busy_cycles++;
    check("done_latency", n, WIDTH);
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
    check("ovf", ovf, exp_ovf);
    tick();
    check("busy_cycles", busy_cycles, WIDTH + 1);
    check("busy_after", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    check("sum_hold", sum, exp_sum);
  endtask

  initial begin
    int dones;
    int last_t;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    logic [WIDTH:0]   full;

    reset = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();

    // Directed vectors
    do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_add(8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1);
    do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_add(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    do_add(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    // Start pulse with different operands during SHIFT must be ignored
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int t = 0; t < 16; t++) begin
      if (done) begin
        dones++;
        check("busy_ignore_sum", sum, 8'h00);
        check("busy_ignore_cout", cout, 1'b1);
        check("busy_ignore_ovf", ovf, 1'b0);
      end
      tick();
    end
    check("busy_ignore_dones", dones, 1);

    // Start held high: done every WIDTH+2 cycles
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    dones = 0;
    last_t = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (done) begin
        dones++;
        check("held_sum", sum, 8'h07);
        if (dones == 1) check("held_first", t, WIDTH + 1);
        else            check("held_period", t - last_t, WIDTH + 2);
        last_t = t;
      end
    end
    start = 1'b0;
    check("held_dones", dones, 3);
    tick();
    tick();

    // Reset in the middle of SHIFT aborts the add
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    dones = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);
    do_add(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);

    // Random vectors against an arithmetic reference
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      do_add(ra, rb, rc, full[WIDTH-1:0], full[WIDTH],
             (ra[WIDTH-1] == rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
